collision_poll_sequencer: RTL
=============================

COLLISION_POLL_SEQUENCER -- requirements
Module: collision_poll_sequencer

Interface
REQ-001 SHALL have parameter MARIO_SIZE, default 10'd20, half-extent of Mario in pixels on both axes.
REQ-002 SHALL have parameter RD_LATENCY, fixed at 1, the map read latency in Clk cycles; no other value is supported.
REQ-003 Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 frame_clk  input  1  vertical-sync rate tick; its rising edge starts one poll sweep.
REQ-006 Mario_X_Pos, Mario_Y_Pos  input  10 each  Mario centre, screen pixels.
REQ-007 Scroll_Col  input  8  map column shown at screen column 0.
REQ-008 rend_req  input  1  renderer requests the map port this cycle.
REQ-009 rend_addr  input  12  renderer map address.
REQ-010 map_addr  output  12  address to the single-port level map; 12 bits = {row[3:0], col[7:0]}.
REQ-011 map_data  input  3  tile code returned 1 cycle after the address is presented.
REQ-012 mario_poll_up, mario_poll_down, mario_poll_left, mario_poll_right  output  3 each  tile codes adjacent to Mario.
REQ-013 poll_valid  output  1  one-cycle pulse when all four poll outputs update.
REQ-014 poll_busy  output  1  sweep in progress.
REQ-015 poll_overrun  output  1  one-cycle pulse when a frame edge arrives while busy.

Function
REQ-016 The frame edge SHALL be detected with a delayed-sample register and a registered edge flag (edge flag high 1 cycle).
REQ-017 map_addr SHALL equal rend_addr whenever rend_req=1; the renderer always wins, combinationally, with no grant signal.
REQ-018 FSM states: IDLE, PROBE, CAPTURE, COMMIT; a 2-bit probe index is ordered up=0, down=1, left=2, right=3.
REQ-019 In IDLE with the edge flag high: latch X, Y and Scroll_Col; clear the index; go to PROBE.
REQ-020 Probe points are up (X, Y-SIZE-1), down (X, Y+SIZE), left (X-SIZE-1, Y), right (X+SIZE, Y), all in 10-bit modulo arithmetic.
REQ-021 A probe with px>=640 or py>=480 (including underflow wrap) SHALL yield 3'b111 with no map access; PROBE stores it and advances in 1 cycle.
REQ-022 In-range address: row=py[8:5]; col=(Scroll_Col + px[9:5]) mod 256.
REQ-023 In PROBE with an in-range point: if rend_req=1, stall in PROBE; otherwise drive the address and go to CAPTURE.
REQ-024 CAPTURE SHALL store map_data into the shadow slot for the index; on index 3 go to COMMIT, else increment the index and go to PROBE.
REQ-025 COMMIT SHALL copy all four shadow slots to the outputs in the same edge that pulses poll_valid, then go to IDLE; the outputs never show a mixed sweep.
REQ-026 Uncontended, all in range: outputs and poll_valid SHALL change exactly 10 cycles after the edge-flag cycle; each stall cycle adds 1 and each out-of-range probe subtracts 1.
REQ-027 An edge flag outside IDLE SHALL pulse poll_overrun; that edge is dropped and the current sweep continues.
REQ-028 poll_busy=1 in every state except IDLE.

Reset
REQ-029 Reset SHALL force IDLE, the index to 0, all poll outputs and shadows to 3'b111, poll_valid, poll_overrun and the edge registers to 0, and the latched X, Y and Scroll_Col to 0.
REQ-030 Reset mid-sweep SHALL abandon the sweep without a poll_valid pulse.

Structure
REQ-031 A shared package SHALL hold: TILE_SHIFT=5, MAP_COL_BITS=8, MAP_ROW_BITS=4, SCREEN_W=640, SCREEN_H=480, TILE_SOLID=3'b111, TILE_EMPTY=3'b000, the FSM state enum and the probe index enum.
REQ-032 A combinational sub-module probe_addr_gen SHALL map (point, Scroll_Col) to (address, out_of_range).

Verification
REQ-033 X=140, Y=419, Scroll_Col=0, no rend_req -> addresses 0xC04, 0xD04, 0xD03, 0xD05 in order; poll_valid 10 cycles after the edge flag.
REQ-034 Same setup, Scroll_Col=254 -> right-probe address 0xD03 (column wrap).
REQ-035 Y=10 -> up=3'b111, only 3 map reads, poll_valid 9 cycles after the edge flag.
REQ-036 rend_req held high for 5 cycles during the down probe -> map_addr equals rend_addr throughout; poll_valid is delayed by exactly 5 cycles.
REQ-037 A second frame edge 4 cycles into a sweep -> one poll_overrun pulse; exactly one poll_valid pulse.
REQ-038 Reset asserted during CAPTURE -> outputs read 3'b111 immediately; no poll_valid pulse.

Source files
------------

// File: rtl/collision_poll_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// collision_poll_sequencer_pkg
// Shared constants and types for the collision poll sequencer: tile geometry,
// level-map address layout, visible screen bounds, tile codes, the sweep FSM
// state enum and the probe index enum.
// -----------------------------------------------------------------------------
package collision_poll_sequencer_pkg;

  localparam int TILE_SHIFT   = 5;    // tiles are 32x32 pixels
  localparam int MAP_COL_BITS = 8;
  localparam int MAP_ROW_BITS = 4;
  localparam int MAP_ADDR_W   = MAP_ROW_BITS + MAP_COL_BITS;
  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;

  localparam logic [2:0] TILE_SOLID = 3'b111;
  localparam logic [2:0] TILE_EMPTY = 3'b000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PROBE   = 2'd1,
    CAPTURE = 2'd2,
    COMMIT  = 2'd3
  } poll_state_e;

  typedef enum logic [1:0] {
    PRB_UP    = 2'd0,
    PRB_DOWN  = 2'd1,
    PRB_LEFT  = 2'd2,
    PRB_RIGHT = 2'd3
  } probe_idx_e;

endpackage

// File: rtl/collision_poll_sequencer_if.sv
// -----------------------------------------------------------------------------
// collision_poll_sequencer_if
// Level-map port bundle shared by the renderer, the poll sequencer and the
// single-port map RAM.
//   rend_req  : renderer wants the map port this cycle
//   rend_addr : renderer map address
//   map_addr  : address presented to the map ({row[3:0], col[7:0]})
//   map_data  : tile code, valid one cycle after map_addr
// master = sequencer side, slave = renderer/map side.
// -----------------------------------------------------------------------------
interface collision_poll_sequencer_if;
  import collision_poll_sequencer_pkg::*;

  logic                  rend_req;
  logic [MAP_ADDR_W-1:0] rend_addr;
  logic [MAP_ADDR_W-1:0] map_addr;
  logic [2:0]            map_data;

  modport master (
    input  rend_req,
    input  rend_addr,
    input  map_data,
    output map_addr
  );

  modport slave (
    output rend_req,
    output rend_addr,
    output map_data,
    input  map_addr
  );
endinterface

// File: rtl/collision_poll_sequencer_probe_addr_gen.sv
// -----------------------------------------------------------------------------
// probe_addr_gen
// Combinational mapping of a screen-space probe point to a level-map address.
//   px_i, py_i : probe point (10-bit screen pixels, may be wrapped)
//   scroll_i   : map column shown at screen column 0
//   addr_o     : {row, col} map address
//   oor_o      : point lies outside the visible screen
// -----------------------------------------------------------------------------
module probe_addr_gen
  import collision_poll_sequencer_pkg::*;
(
  input  logic [9:0]            px_i,
  input  logic [9:0]            py_i,
  input  logic [7:0]            scroll_i,
  output logic [MAP_ADDR_W-1:0] addr_o,
  output logic                  oor_o
);

  logic [MAP_ROW_BITS-1:0] row;
  logic [MAP_COL_BITS-1:0] col;

  // Underflowed points wrap to large values and fall out here as well.
  assign oor_o = (px_i >= 10'(SCREEN_W)) || (py_i >= 10'(SCREEN_H));

  assign row = py_i[TILE_SHIFT+MAP_ROW_BITS-1:TILE_SHIFT];
  // Column addition wraps at 256 so the level loops horizontally.
  assign col = scroll_i + MAP_COL_BITS'(px_i[9:TILE_SHIFT]);

  assign addr_o = {row, col};

endmodule

// File: rtl/collision_poll_sequencer.sv
// -----------------------------------------------------------------------------
// collision_poll_sequencer
// Once per frame, reads the four level-map tiles adjacent to Mario (up, down,
// left, right) through a map port shared with the renderer, and publishes
// them atomically.
// Ports:
//   Clk, Reset              : clock, asynchronous active-high reset
//   frame_clk               : vsync-rate tick, rising edge starts a sweep
//   Mario_X_Pos/Mario_Y_Pos : Mario centre (screen pixels)
//   Scroll_Col              : map column at screen column 0
//   bus                     : map port bundle (renderer always has priority)
//   mario_poll_*            : tile codes around Mario
//   poll_valid              : one-cycle pulse when all four outputs update
//   poll_busy               : sweep in progress
//   poll_overrun            : one-cycle pulse when a frame edge is dropped
// -----------------------------------------------------------------------------
module collision_poll_sequencer
  import collision_poll_sequencer_pkg::*;
#(
  parameter logic [9:0] MARIO_SIZE = 10'd20,
  parameter int         RD_LATENCY = 1
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        frame_clk,
  input  logic [9:0]                  Mario_X_Pos,
  input  logic [9:0]                  Mario_Y_Pos,
  input  logic [7:0]                  Scroll_Col,
  collision_poll_sequencer_if.master  bus,
  output logic [2:0]                  mario_poll_up,
  output logic [2:0]                  mario_poll_down,
  output logic [2:0]                  mario_poll_left,
  output logic [2:0]                  mario_poll_right,
  output logic                        poll_valid,
  output logic                        poll_busy,
  output logic                        poll_overrun
);

  // The CAPTURE state assumes map_data arrives exactly one cycle after the
  // address; any other latency would need extra wait states.
  if (RD_LATENCY != 1) begin : g_rd_latency_check
    $error("collision_poll_sequencer: only RD_LATENCY=1 is supported");
  end

  localparam logic [9:0] SIZE_P1 = MARIO_SIZE + 10'd1;

  poll_state_e           state_q, state_d;
  probe_idx_e            idx_q, idx_d;
  logic [9:0]            x_q, x_d;
  logic [9:0]            y_q, y_d;
  logic [7:0]            scroll_q, scroll_d;
  logic [3:0][2:0]       shadow_q, shadow_d;
  logic [3:0][2:0]       out_q;
  logic                  frame_q;
  logic                  edge_q;
  logic                  valid_q;
  logic                  overrun_q;

  logic [9:0]            px, py;
  logic [MAP_ADDR_W-1:0] probe_addr;
  logic                  probe_oor;
  poll_state_e           adv_state;
  probe_idx_e            adv_idx;

  // Probe point for the current index, 10-bit modulo arithmetic.
  always_comb begin
    px = x_q;
    py = y_q;
    case (idx_q)
      PRB_UP:    py = y_q - SIZE_P1;
      PRB_DOWN:  py = y_q + MARIO_SIZE;
      PRB_LEFT:  px = x_q - SIZE_P1;
      PRB_RIGHT: px = x_q + MARIO_SIZE;
      default:   px = x_q;
    endcase
  end

  probe_addr_gen u_probe_addr_gen (
    .px_i     (px),
    .py_i     (py),
    .scroll_i (scroll_q),
    .addr_o   (probe_addr),
    .oor_o    (probe_oor)
  );

  // Renderer wins the port combinationally; the FSM stalls in PROBE instead.
  assign bus.map_addr = bus.rend_req ? bus.rend_addr : probe_addr;

  // Where to go once the current slot has been stored.
  always_comb begin
    adv_state = PROBE;
    adv_idx   = probe_idx_e'(idx_q + 2'd1);
    if (idx_q == PRB_RIGHT) begin
      adv_state = COMMIT;
      adv_idx   = idx_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    scroll_d = scroll_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (edge_q) begin
          x_d      = Mario_X_Pos;
          y_d      = Mario_Y_Pos;
          scroll_d = Scroll_Col;
          idx_d    = PRB_UP;
          state_d  = PROBE;
        end
      end
      PROBE: begin
        if (probe_oor) begin
          // Off-screen counts as solid and costs no map access.
          shadow_d[idx_q] = TILE_SOLID;
          state_d         = adv_state;
          idx_d           = adv_idx;
        end else if (!bus.rend_req) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        shadow_d[idx_q] = bus.map_data;
        state_d         = adv_state;
        idx_d           = adv_idx;
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= PRB_UP;
      x_q       <= '0;
      y_q       <= '0;
      scroll_q  <= '0;
      shadow_q  <= {4{TILE_SOLID}};
      out_q     <= {4{TILE_SOLID}};
      frame_q   <= 1'b0;
      edge_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      x_q       <= x_d;
      y_q       <= y_d;
      scroll_q  <= scroll_d;
      shadow_q  <= shadow_d;
      frame_q   <= frame_clk;
      edge_q    <= frame_clk & ~frame_q;
      valid_q   <= (state_q == COMMIT);
      overrun_q <= edge_q && (state_q != IDLE);
      // All four outputs move together so a mixed sweep is never visible.
      if (state_q == COMMIT) begin
        out_q <= shadow_q;
      end
    end
  end

  assign mario_poll_up    = out_q[PRB_UP];
  assign mario_poll_down  = out_q[PRB_DOWN];
  assign mario_poll_left  = out_q[PRB_LEFT];
  assign mario_poll_right = out_q[PRB_RIGHT];
  assign poll_valid       = valid_q;
  assign poll_overrun     = overrun_q;
  assign poll_busy        = (state_q != IDLE);

endmodule
